// File: rtl/scam_rr_relay.sv
// scam_rr_relay: polls N_CH blocking producer channels round-robin, queues the
// accepted words in a DEPTH-entry FIFO and forwards them on one output port.
// A running sum of accepted words is kept alongside, with a sticky carry flag.
module scam_rr_relay #(
   parameter int          WIDTH        = 32,
   parameter int          N_CH         = 2,
   parameter int          DEPTH        = 4,
   parameter int          OUT_BLOCKING = 1,
   parameter int unsigned INIT_VAR     = 1337
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_CH*WIDTH-1:0]   ch_in,
   input  logic [N_CH-1:0]         ch_in_sync,
   output logic [N_CH-1:0]         ch_in_notify,
   output logic [WIDTH-1:0]        m_out,
   input  logic                    m_out_sync,
   output logic                    m_out_notify,
   output logic [WIDTH-1:0]        var_out,
   output logic                    sum_ovf
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (N_CH > 1) ? $clog2(N_CH) : 1;

   logic [PW-1:0]    ptr_q, ptr_d;
   logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] out_q, out_d;
   logic [WIDTH-1:0] var_q, var_d;
   logic             ovf_q, ovf_d;

   logic             full, empty, push, pop;
   logic [WIDTH-1:0] push_word;
   logic [WIDTH:0]   sum;

   assign full  = (cnt_q == CW'(DEPTH));
   assign empty = (cnt_q == '0);

   // Only the polled channel is offered, and only while there is room.
   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      assign ch_in_notify[i] = (ptr_q == PW'(i)) && !full;
   end

   assign push = |(ch_in_notify & ch_in_sync);
   // Master mode drains every cycle; blocking mode waits for the consumer.
   assign pop  = !empty && ((OUT_BLOCKING == 0) || m_out_sync);

   // Data of the currently polled channel.
   always_comb begin
      push_word = '0;
      for (int i = 0; i < N_CH; i++)
         if (ptr_q == PW'(i)) push_word = ch_in[i*WIDTH +: WIDTH];
   end

   assign sum = {1'b0, var_q} + {1'b0, push_word};

   // Next state: pointer rotation, FIFO bookkeeping, running sum, output head.
   always_comb begin
      ptr_d = ptr_q;
      rd_d  = rd_q;
      wr_d  = wr_q;
      cnt_d = cnt_q;
      out_d = out_q;
      var_d = var_q;
      ovf_d = ovf_q;
      if (!full)
         ptr_d = (ptr_q == PW'(N_CH - 1)) ? '0 : ptr_q + PW'(1);
      if (push) begin
         wr_d  = wr_q + AW'(1);
         var_d = sum[WIDTH-1:0];
         if (sum[WIDTH]) ovf_d = 1'b1;
      end
      if (pop) rd_d = rd_q + AW'(1);
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
      // Head is registered so it holds its last value once the FIFO empties.
      // If nothing older survives the pop, the head is the word pushed now.
      if (cnt_d != '0)
         out_d = (cnt_q == CW'(pop)) ? push_word : mem_q[rd_d];
   end

   // State registers with synchronous flush.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
         out_q <= '0;
         var_q <= WIDTH'(INIT_VAR);
         ovf_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
         rd_q  <= rd_d;
         wr_q  <= wr_d;
         cnt_q <= cnt_d;
         out_q <= out_d;
         var_q <= var_d;
         ovf_q <= ovf_d;
      end
   end

   // FIFO storage; contents need no reset since the count gates visibility.
   always_ff @(posedge clk) begin
      if (!rst && push) mem_q[wr_q] <= push_word;
   end

   assign m_out        = out_q;
   assign m_out_notify = !empty;
   assign var_out      = var_q;
   assign sum_ovf      = ovf_q;

endmodule
